// File: rtl/gh_stream_transpose.sv
// gh_stream_transpose
// -----------------------------------------------------------------------------
// Streaming byte-transpose of a LANES x LANES byte matrix (the Groestl state
// for LANES = 8, BYTE_W = 8). Row words are received one per cycle, and the
// same block is returned transposed, as column words, one per cycle. Two banks
// are used in ping-pong fashion so that one block can be filled while the
// other block is drained. This sustains one word per cycle on both sides.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   clr_i        synchronous flush (same effect as rst_i)
//   in_valid_i   input row word valid
//   in_ready_o   a row word can be accepted (depends on registers only)
//   in_data_i    row word k, byte b = in_data_i[BYTE_W*b +: BYTE_W]
//   out_valid_o  output column word valid
//   out_ready_i  consumer accepts the column word
//   out_data_o   column word j, byte i = element (row i, byte j); zero when idle
//   out_last_o   asserted with the final column word of a block
// -----------------------------------------------------------------------------
module gh_stream_transpose #(
  parameter int LANES  = 8,
  parameter int BYTE_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*BYTE_W-1:0] in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*BYTE_W-1:0] out_data_o,
  output logic                    out_last_o
);

  localparam int               WORD_W  = LANES * BYTE_W;
  localparam int               CNT_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LANES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // bank_q[bank][row][byte]
  logic [BYTE_W-1:0] bank_q [2][LANES][LANES];

  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  logic             wr_fire_s;
  logic             rd_fire_s;
  logic [WORD_W-1:0] col_s;

  // Handshake qualifiers. Both are derived from registered flags only.
  always_comb begin
    in_ready_o  = ~full_q[wr_sel_q];
    out_valid_o = full_q[rd_sel_q];
    wr_fire_s   = in_valid_i & ~full_q[wr_sel_q];
    rd_fire_s   = full_q[rd_sel_q] & out_ready_i;
  end

  // Column gather: byte i of the column word is byte rd_cnt of row i.
  always_comb begin
    col_s = '0;
    for (int i = 0; i < LANES; i++) begin
      col_s[BYTE_W*i +: BYTE_W] = bank_q[rd_sel_q][i][rd_cnt_q];
    end
  end

  // Output word and last flag, forced to zero while no block is ready.
  always_comb begin
    if (full_q[rd_sel_q]) begin
      out_data_o = col_s;
      out_last_o = (rd_cnt_q == CNT_MAX);
    end else begin
      out_data_o = '0;
      out_last_o = 1'b0;
    end
  end

  // Next-state logic for the write and read sides. A write only targets a
  // non-full bank and a read only targets a full bank. Therefore the two flag
  // updates never touch the same bank in the same cycle.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;

    if (wr_fire_s) begin
      if (wr_cnt_q == CNT_MAX) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        wr_cnt_d         = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_ONE;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    if (rd_fire_s) begin
      if (rd_cnt_q == CNT_MAX) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        rd_cnt_d         = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + CNT_ONE;
      end
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Control registers. A flush discards every partial or buffered block.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Byte storage has no reset. Stale contents are unreachable because the
  // full flags are cleared.
  always_ff @(posedge clk_i) begin
    if (wr_fire_s && !rst_i && !clr_i) begin
      for (int b = 0; b < LANES; b++) begin
        bank_q[wr_sel_q][wr_cnt_q][b] <= in_data_i[BYTE_W*b +: BYTE_W];
      end
    end
  end

endmodule

// File: tb/tb_gh_stream_transpose.sv
module tb_gh_stream_transpose;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clr_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_data_i = 64'd0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [63:0] out_data_o;
  logic        out_last_o;

  int checks_cnt = 0;
  int err_cnt    = 0;

  // reference model state
  logic [63:0] exp_q[$];
  logic [63:0] row_buf [8];
  int wr_pos    = 0;
  int rd_pos    = 0;
  int in_words  = 0;
  int out_words = 0;

  gh_stream_transpose #(.LANES(8), .BYTE_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // byte b of row k = {k[3:0], b[3:0]}
  function automatic logic [63:0] pat1(input int k);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'(k * 16 + b);
    return w;
  endfunction

  // byte b of row k in block n = k*8 + b + n
  function automatic logic [63:0] pat2(input int n, input int k);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'(k * 8 + b + n);
    return w;
  endfunction

  task automatic drive(input logic v, input logic [63:0] d, input logic r);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    #1;
  endtask

  // Update the model with this cycle's handshakes, then advance one clock.
  task automatic tick();
    logic [63:0] col;
    if (rst_i || clr_i) begin
      exp_q.delete();
      wr_pos = 0;
      rd_pos = 0;
    end else begin
      if (in_valid_i && in_ready_o) begin
        row_buf[wr_pos] = in_data_i;
        wr_pos++;
        in_words++;
        if (wr_pos == 8) begin
          for (int j = 0; j < 8; j++) begin
            col = 64'd0;
            for (int i = 0; i < 8; i++) col[8*i +: 8] = row_buf[i][8*j +: 8];
            exp_q.push_back(col);
          end
          wr_pos = 0;
        end
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) check_val("spurious_out", {63'd0, out_valid_o}, 64'd0);
        else check_val("out_data", out_data_o, exp_q.pop_front());
        check_val("out_last", {63'd0, out_last_o}, (rd_pos == 7) ? 64'd1 : 64'd0);
        rd_pos = (rd_pos + 1) % 8;
        out_words++;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_drain(input int n);
    for (int c = 0; c < n; c++) begin
      drive(1'b0, 64'd0, 1'b1);
      tick();
    end
  endtask

  initial begin
    int target;
    int in_target;

    // reset
    rst_i = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    check_val("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    check_val("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check_val("rst_out_data", out_data_o, 64'd0);
    check_val("rst_out_last", {63'd0, out_last_o}, 64'd0);

    // test 1: single block
    check_val("t1_word0_pattern", pat1(0), 64'h0706050403020100);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, pat1(k), 1'b1);
      check_val("t1_valid_before", {63'd0, out_valid_o}, 64'd0);
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      drive(1'b0, 64'd0, 1'b1);
      check_val("t1_valid", {63'd0, out_valid_o}, 64'd1);
      if (j == 0) check_val("t1_col0", out_data_o, 64'h7060504030201000);
      if (j == 7) check_val("t1_col7", out_data_o, 64'h7767574737271707);
      check_val("t1_last", {63'd0, out_last_o}, (j == 7) ? 64'd1 : 64'd0);
      tick();
    end
    drive(1'b0, 64'd0, 1'b1);
    check_val("t1_valid_after", {63'd0, out_valid_o}, 64'd0);

    // test 2: four back-to-back blocks
    for (int t = 0; t < 40; t++) begin
      if (t < 32) drive(1'b1, pat2(t / 8, t % 8), 1'b1);
      else drive(1'b0, 64'd0, 1'b1);
      if (t < 32) check_val("t2_in_ready", {63'd0, in_ready_o}, 64'd1);
      check_val("t2_out_valid", {63'd0, out_valid_o}, (t >= 8) ? 64'd1 : 64'd0);
      tick();
    end
    check_val("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // test 3: backpressure
    for (int t = 0; t < 16; t++) begin
      drive(1'b1, (t < 8) ? pat1(t) : pat2(1, t - 8), 1'b0);
      check_val("t3_in_ready_fill", {63'd0, in_ready_o}, 64'd1);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, pat2(2, c), 1'b0);
      check_val("t3_in_ready_full", {63'd0, in_ready_o}, 64'd0);
      check_val("t3_hold_valid", {63'd0, out_valid_o}, 64'd1);
      check_val("t3_hold_data", out_data_o, 64'h7060504030201000);
      check_val("t3_hold_last", {63'd0, out_last_o}, 64'd0);
      tick();
    end
    for (int d = 0; d < 16; d++) begin
      drive(1'b0, 64'd0, 1'b1);
      check_val("t3_drain_valid", {63'd0, out_valid_o}, 64'd1);
      check_val("t3_in_ready_drain", {63'd0, in_ready_o}, (d >= 8) ? 64'd1 : 64'd0);
      tick();
    end
    drive(1'b0, 64'd0, 1'b0);
    check_val("t3_valid_after", {63'd0, out_valid_o}, 64'd0);
    check_val("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // test 4: random handshakes, 100 blocks
    target    = out_words + 800;
    in_target = in_words + 800;
    for (int c = 0; c < 6000 && out_words < target; c++) begin
      drive((in_words < in_target) ? 1'($urandom_range(0, 1)) : 1'b0,
            {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
      tick();
    end
    check_val("t4_out_count", 64'(out_words), 64'(target));
    check_val("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // test 5: clr with block 0 half read and block 1 partly written
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, pat2(5, k), 1'b0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, pat2(6, k), 1'b1);
      tick();
    end
    clr_i = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    tick();
    clr_i = 1'b0;
    drive(1'b0, 64'd0, 1'b1);
    check_val("t5_out_valid", {63'd0, out_valid_o}, 64'd0);
    check_val("t5_in_ready", {63'd0, in_ready_o}, 64'd1);
    check_val("t5_out_data", out_data_o, 64'd0);
    check_val("t5_out_last", {63'd0, out_last_o}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, pat2(7, k), 1'b1);
      tick();
    end
    idle_drain(12);
    check_val("t5_sb_empty", 64'(exp_q.size()), 64'd0);
    drive(1'b0, 64'd0, 1'b1);
    check_val("t5_valid_after", {63'd0, out_valid_o}, 64'd0);

    // test 6: one-cycle rst mid-stream
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, pat2(8, k % 8), 1'(k % 2));
      tick();
    end
    rst_i = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    tick();
    rst_i = 1'b0;
    drive(1'b0, 64'd0, 1'b1);
    check_val("t6_in_ready", {63'd0, in_ready_o}, 64'd1);
    check_val("t6_out_valid", {63'd0, out_valid_o}, 64'd0);
    check_val("t6_out_data", out_data_o, 64'd0);
    check_val("t6_out_last", {63'd0, out_last_o}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, pat2(9, k), 1'b1);
      tick();
    end
    idle_drain(12);
    check_val("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    drive(1'b0, 64'd0, 1'b1);
    check_val("t6_valid_after", {63'd0, out_valid_o}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/gh_stream_transpose.md
Name: gh_stream_transpose

Overview:
- Streaming, word-serial counterpart of the parallel Grøstl byte-transpose permutation.
- Accepts a 512-bit state as 8 row words of 64 bits over a valid/ready interface and emits the same state transposed, as 8 column words, over a second valid/ready interface.
- Ping-pong buffered, so it sustains one word per cycle in and out.
- Sits between the narrow datapath feeding the round core and any consumer that needs the transposed state word by word.

Parameters:
- LANES, 8, bytes per word and words per block (square matrix); supported value 8, other powers of two must also elaborate.
- BYTE_W, 8, bits per byte lane; word width is LANES*BYTE_W.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; drops all buffered and partial blocks.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  LANES*BYTE_W  row word k; byte b = in_data[BYTE_W*b +: BYTE_W].
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  LANES*BYTE_W  column word j; byte i = element (row i, byte j).
- out_last  out  1  high with the final column word (j = LANES-1) of a block.

Behaviour:
- Storage: two banks, each LANES x LANES bytes; per-bank full flag; wr_sel and rd_sel bank pointers; wr_cnt and rd_cnt, each log2(LANES) bits.
- Mapping: input word k, byte b goes to bank[wr_sel][k][b]. Output word j, byte i = bank[rd_sel][i][j].
  - Concatenating inputs as state[64k +: 64] and outputs as result[64j +: 64] gives result[64j+8i +: 8] = state[64i+8j +: 8], identical to the parallel transpose.
- in_ready = !full[wr_sel] (combinational from registers; does not depend on in_valid).
- Write accept (in_valid && in_ready): store the word and increment wr_cnt.
  - On the write with wr_cnt = LANES-1: set full[wr_sel], toggle wr_sel, wrap wr_cnt to 0.
- out_valid = full[rd_sel].
- out_data = transposed column rd_cnt of bank[rd_sel] when out_valid; all zeros when out_valid = 0.
- out_last = out_valid && (rd_cnt == LANES-1).
- Read accept (out_valid && out_ready): increment rd_cnt.
  - On the read with rd_cnt = LANES-1: clear full[rd_sel], toggle rd_sel, wrap rd_cnt to 0.
- Latency: the first column word is valid on the cycle after the 8th row word is accepted.
- Throughput: with continuous in_valid and out_ready, 1 word/cycle each side. in_ready stays high in steady state.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable. Input continues into the other bank until that bank is full, then in_ready drops.
- Simultaneous events:
  - Completing a write to one bank while completing a read of the other in the same cycle: both flags update in that cycle.
  - A read may clear full on the same bank the write side is waiting on. in_ready rises the next cycle, not combinationally.
- The same bank can never be written and read at once (guaranteed by the full flags). No bypass path.
- rst or clr (rst has priority, clr has identical effect): full flags = 0, wr_sel = rd_sel = 0, wr_cnt = rd_cnt = 0. Byte storage is not cleared.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0.
  - A partially written or partially read block is discarded. No word from before rst/clr ever appears after it.
- in_data is ignored when in_valid = 0 or in_ready = 0.

Test Plan:
1. Single block, out_ready = 1. Send in word k with byte b = {k[3:0], b[3:0]}; word 0 = 64'h0706050403020100. Required: out_valid asserts the cycle after word 7 is accepted. out word 0 = 64'h7060504030201000, out word 7 = 64'h7767574737271707. out_last only on word 7.
2. Streaming: 4 back-to-back blocks (block n byte = k*8+b+n), out_ready = 1. Required: in_ready never drops, 32 output words with no gaps after first-word latency, each block equal to the parallel-transpose reference model.
3. Backpressure: out_ready = 0 during blocks 0 and 1. Required: in_ready drops after the 16th word accepted. out_data holds 64'h7060504030201000 stable. Releasing out_ready drains 16 words in order; in_ready returns 1 the cycle after block 0's last read.
4. Random in_valid/out_ready (50% each), 100 blocks. Required: exact scoreboard match, out_last every 8th output, no loss or duplication.
5. clr after 5 words of block 1, with block 0 half-read. Required next cycle: out_valid = 0, in_ready = 1. A fresh block then outputs correctly, with no stale words.
6. rst asserted mid-stream for 1 cycle. Required: same state as clr. After rst: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0.
